water_sensor_conditioner: RTL and testbench



---
 rtl/wm_pkg.sv | 21 ++
 rtl/water_sensor_conditioner_if.sv | 33 +++
 rtl/level_debouncer.sv | 36 +++
 rtl/water_sensor_conditioner.sv | 135 +++++++++++++
 tb/tb_water_sensor_conditioner.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the water sensor conditioner: FSM state encoding,
// datapath widths and default tuning constants.
package wm_pkg;

  localparam int LEVEL_W = 3;
  localparam int TIMER_W = 8;
  localparam int CNT_W   = 4;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_FLOW_DEBOUNCE = 3;
  localparam int DEF_FILL_TIMEOUT  = 32;
  localparam int DEF_MAX_RETRIES   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    FAULT   = 2'd2,
    LOCKOUT = 2'd3
  } wm_state_e;

endpackage

// File: rtl/water_sensor_conditioner_if.sv
// Bundle of sensor, controller and status signals around the conditioner.
interface water_sensor_conditioner_if;
  import wm_pkg::*;

  logic [LEVEL_W-1:0] raw_level;
  logic               raw_flow;
  logic               fill_req;
  logic [LEVEL_W-1:0] target_level;
  logic               retry;
  logic [LEVEL_W-1:0] level;
  logic               waterflow;
  logic               fill_done;
  logic               flow_fault;
  logic               lockout;
  logic [1:0]         fault_count;
  wm_state_e          state;

  // Signalling: there is no valid/ready pair. fill_req is a level held by the
  // controller for as long as it wants water; retry is a one-cycle pulse that
  // only acts in FAULT while fill_req is high; fill_done is a one-cycle pulse
  // and is never high together with flow_fault. All outputs are registered and
  // describe the state after the most recent clock edge. state is debug only.
  modport master (
    output raw_level, raw_flow, fill_req, target_level, retry,
    input  level, waterflow, fill_done, flow_fault, lockout, fault_count, state
  );

  modport slave (
    input  raw_level, raw_flow, fill_req, target_level, retry,
    output level, waterflow, fill_done, flow_fault, lockout, fault_count, state
  );

endinterface

// File: rtl/level_debouncer.sv
// Generic bus debouncer: the output follows the raw bus only after the raw
// value has been sampled identical on STABLE_CYCLES consecutive edges.
module level_debouncer #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);
  import wm_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt;

  // Track the current candidate and how many edges it has been seen; the
  // counter parks at its last value so a long-held value stays published.
  always_ff @(posedge clk) begin
    if (reset) begin
      candidate <= '0;
      cnt       <= '0;
      stable    <= '0;
    end else if (raw != candidate) begin
      candidate <= raw;
      cnt       <= CNT_W'(1);
    end else if (cnt == CNT_LAST) begin
      stable    <= candidate;
    end else begin
      cnt       <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/water_sensor_conditioner.sv
// Sits between raw tank sensors and the washing machine controller:
// debounces the level sensor, supervises fill requests, detects timeouts and
// flow loss, counts faults and locks out after repeated faults.
module water_sensor_conditioner
  import wm_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int FLOW_DEBOUNCE = DEF_FLOW_DEBOUNCE,
  parameter int FILL_TIMEOUT  = DEF_FILL_TIMEOUT,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input logic                        clk,
  input logic                        reset,
  water_sensor_conditioner_if.slave  bus
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   FLOW_LAST  = CNT_W'(FLOW_DEBOUNCE);
  localparam logic [1:0]         FAULT_MAX  = 2'(MAX_RETRIES);

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] level_prev;
  wm_state_e          state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [CNT_W-1:0]   flow_cnt;
  logic [CNT_W-1:0]   flow_next;
  logic [1:0]         fault_count;
  logic [1:0]         fault_count_next;
  logic               waterflow;
  logic               fill_done;
  logic               flow_fault;
  logic               lockout;
  logic               level_rise;
  logic               level_reached;
  logic               fault_hit;

  level_debouncer #(
    .WIDTH         (LEVEL_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_level_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (bus.raw_level),
    .stable (level)
  );

  // Next values of the fill supervision counters and the fault decision.
  // Both limits are tested on the value the counter is about to take, so a
  // rise in level on the same edge keeps the timer from faulting.
  always_comb begin
    level_rise       = level > level_prev;
    level_reached    = level >= bus.target_level;
    timer_next       = level_rise ? '0 : timer + TIMER_W'(1);
    flow_next        = bus.raw_flow ? '0 : flow_cnt + CNT_W'(1);
    fault_hit        = (flow_next == FLOW_LAST) || (timer_next == TIMER_LAST);
    fault_count_next = (fault_count == FAULT_MAX) ? fault_count : fault_count + 2'd1;
  end

  // Supervision FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      level_prev  <= '0;
      timer       <= '0;
      flow_cnt    <= '0;
      fault_count <= '0;
      waterflow   <= 1'b1;
      fill_done   <= 1'b0;
      flow_fault  <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      level_prev <= level;
      fill_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fill_req) begin
            state    <= FILLING;
            timer    <= '0;
            flow_cnt <= '0;
          end
        end
        FILLING: begin
          if (!bus.fill_req) begin
            state <= IDLE;
          end else if (level_reached) begin
            state     <= IDLE;
            fill_done <= 1'b1;
          end else if (fault_hit) begin
            fault_count <= fault_count_next;
            waterflow   <= 1'b0;
            if (fault_count_next == FAULT_MAX) begin
              state   <= LOCKOUT;
              lockout <= 1'b1;
            end else begin
              state      <= FAULT;
              flow_fault <= 1'b1;
            end
          end else begin
            timer    <= timer_next;
            flow_cnt <= flow_next;
          end
        end
        FAULT: begin
          if (!bus.fill_req) begin
            state      <= IDLE;
            flow_fault <= 1'b0;
            waterflow  <= 1'b1;
          end else if (bus.retry) begin
            state      <= FILLING;
            timer      <= '0;
            flow_cnt   <= '0;
            flow_fault <= 1'b0;
            waterflow  <= 1'b1;
          end
        end
        LOCKOUT: begin
          state <= LOCKOUT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.level       = level;
  assign bus.waterflow   = waterflow;
  assign bus.fill_done   = fill_done;
  assign bus.flow_fault  = flow_fault;
  assign bus.lockout     = lockout;
  assign bus.fault_count = fault_count;
  assign bus.state       = state;

endmodule

// File: tb/tb_water_sensor_conditioner.sv
// Self-checking bench for water_sensor_conditioner: directed scenarios with
// literal expectations plus randomized stimulus against a behavioural model.
module tb_water_sensor_conditioner;
  import wm_pkg::*;

  localparam int S_CYC   = DEF_STABLE_CYCLES;
  localparam int FLOW_DB = DEF_FLOW_DEBOUNCE;
  localparam int FILL_TO = DEF_FILL_TIMEOUT;
  localparam int MAX_RT  = DEF_MAX_RETRIES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  water_sensor_conditioner_if wif();

  water_sensor_conditioner #(
    .STABLE_CYCLES (S_CYC),
    .FLOW_DEBOUNCE (FLOW_DB),
    .FILL_TIMEOUT  (FILL_TO),
    .MAX_RETRIES   (MAX_RT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (wif)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // ---------------- behavioural model ----------------
  // Level: published value is v once the last S_CYC samples since reset were
  // all v. Supervision tracked as a mode plus "cycles without a level rise" and
  // "consecutive flow-low samples"; outputs derive from the mode.
  wm_state_e  m_mode = IDLE;
  int         m_nr = 0;
  int         m_low = 0;
  int         m_faults = 0;
  bit         m_fd = 1'b0;
  logic [2:0] m_level = '0;
  logic [2:0] m_level_prev = '0;
  logic [2:0] m_level_new;
  logic [2:0] hist[$];
  bit         m_rise;
  bit         all_same;
  int         nr_n;
  int         low_n;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = IDLE; m_nr = 0; m_low = 0; m_faults = 0; m_fd = 1'b0;
      m_level = '0; m_level_prev = '0;
      hist.delete();
    end else begin
      m_rise = m_level > m_level_prev;
      m_fd = 1'b0;
      case (m_mode)
        IDLE: if (wif.fill_req) begin m_mode = FILLING; m_nr = 0; m_low = 0; end
        FILLING: begin
          nr_n  = m_rise ? 0 : m_nr + 1;
          low_n = wif.raw_flow ? 0 : m_low + 1;
          if (!wif.fill_req) m_mode = IDLE;
          else if (m_level >= wif.target_level) begin m_fd = 1'b1; m_mode = IDLE; end
          else if (low_n >= FLOW_DB || nr_n >= FILL_TO - 1) begin
            if (m_faults < MAX_RT) m_faults = m_faults + 1;
            exp_q.push_back(2'(m_faults));
            m_mode = (m_faults == MAX_RT) ? LOCKOUT : FAULT;
          end else begin
            m_nr = nr_n; m_low = low_n;
          end
        end
        FAULT: begin
          if (!wif.fill_req) m_mode = IDLE;
          else if (wif.retry) begin m_mode = FILLING; m_nr = 0; m_low = 0; end
        end
        default: m_mode = m_mode;
      endcase
      hist.push_back(wif.raw_level);
      if (hist.size() > S_CYC) void'(hist.pop_front());
      m_level_new = m_level;
      if (hist.size() == S_CYC) begin
        all_same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) all_same = 1'b0;
        if (all_same) m_level_new = hist[0];
      end
      m_level_prev = m_level;
      m_level = m_level_new;
    end
  end

  // ---------------- compare process ----------------
  bit ev_prev = 1'b0;
  bit ev;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("level",       8'(wif.level),       8'(m_level));
      check("state",       8'(wif.state),       8'(m_mode));
      check("waterflow",   8'(wif.waterflow),   8'((m_mode == FAULT || m_mode == LOCKOUT) ? 0 : 1));
      check("fill_done",   8'(wif.fill_done),   8'(m_fd));
      check("flow_fault",  8'(wif.flow_fault),  8'(m_mode == FAULT));
      check("lockout",     8'(wif.lockout),     8'(m_mode == LOCKOUT));
      check("fault_count", 8'(wif.fault_count), 8'(m_faults));
      ev = wif.flow_fault | wif.lockout;
      if (ev && !ev_prev) begin
        check("fault_event_pending", 8'(exp_q.size() != 0), 8'd1);
        if (exp_q.size() != 0) check("fault_event_count", 8'(wif.fault_count), 8'(exp_q.pop_front()));
      end
      ev_prev = ev;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int dones;
  int wf_low;

  initial begin
    wif.raw_level = '0; wif.raw_flow = 1'b1; wif.fill_req = 1'b0;
    wif.target_level = '0; wif.retry = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    check("rst_level", 8'(wif.level), 8'd0);
    check("rst_waterflow", 8'(wif.waterflow), 8'd1);
    check("rst_fault_count", 8'(wif.fault_count), 8'd0);
    check("rst_lockout", 8'(wif.lockout), 8'd0);
    reset = 1'b0;
    tick(5);

    // Debounce 0 -> 5, then a 3-cycle glitch to 2
    wif.raw_level = 3'd5;
    tick(3);
    check("deb_not_yet", 8'(wif.level), 8'd0);
    tick(1);
    check("deb_rise", 8'(wif.level), 8'd5);
    wif.raw_level = 3'd2;
    tick(3);
    wif.raw_level = 3'd5;
    tick(6);
    check("glitch_hold", 8'(wif.level), 8'd5);

    // Normal fill with ramp 0..4
    wif.raw_level = 3'd0;
    tick(6);
    wif.target_level = 3'd4;
    wif.fill_req = 1'b1;
    dones = 0; wf_low = 0;
    for (int v = 0; v <= 4; v++) begin
      wif.raw_level = 3'(v);
      repeat (6) begin
        tick(1);
        if (wif.fill_done) begin dones++; wif.fill_req = 1'b0; end
        if (!wif.waterflow) wf_low++;
      end
    end
    check("fill_done_pulses", 8'(dones), 8'd1);
    check("fill_waterflow_low_cycles", 8'(wf_low), 8'd0);

    // Timeout with level frozen at 2
    wif.fill_req = 1'b0;
    wif.raw_level = 3'd2;
    tick(6);
    wif.target_level = 3'd6;
    wif.fill_req = 1'b1;
    tick(31);
    check("to_still_filling", 8'(wif.waterflow), 8'd1);
    tick(1);
    check("to_flow_fault", 8'(wif.flow_fault), 8'd1);
    check("to_waterflow", 8'(wif.waterflow), 8'd0);
    check("to_fault_count", 8'(wif.fault_count), 8'd1);
    wif.retry = 1'b1;
    tick(1);
    wif.retry = 1'b0;
    check("retry_waterflow", 8'(wif.waterflow), 8'd1);
    check("retry_clears_fault", 8'(wif.flow_fault), 8'd0);

    // Flow loss: 2 low samples tolerated, 3 faults
    wif.raw_flow = 1'b0;
    tick(2);
    wif.raw_flow = 1'b1;
    tick(1);
    check("flow_short_no_fault", 8'(wif.flow_fault), 8'd0);
    wif.raw_flow = 1'b0;
    tick(3);
    wif.raw_flow = 1'b1;
    check("flow_loss_fault", 8'(wif.flow_fault), 8'd1);
    check("flow_loss_count", 8'(wif.fault_count), 8'd2);

    // Third fault locks out; retry has no effect; reset recovers
    wif.retry = 1'b1;
    tick(1);
    wif.retry = 1'b0;
    wif.raw_flow = 1'b0;
    tick(3);
    wif.raw_flow = 1'b1;
    check("lock_lockout", 8'(wif.lockout), 8'd1);
    check("lock_waterflow", 8'(wif.waterflow), 8'd0);
    check("lock_fault_count", 8'(wif.fault_count), 8'd3);
    wif.retry = 1'b1;
    tick(1);
    wif.retry = 1'b0;
    tick(1);
    check("lock_retry_ignored", 8'(wif.lockout), 8'd1);
    pulse_reset();
    check("unlock_lockout", 8'(wif.lockout), 8'd0);
    check("unlock_waterflow", 8'(wif.waterflow), 8'd1);
    check("unlock_fault_count", 8'(wif.fault_count), 8'd0);
    check("unlock_level", 8'(wif.level), 8'd0);

    // Reset mid-fill with the timer at 20
    wif.fill_req = 1'b0;
    tick(6);
    wif.target_level = 3'd6;
    wif.fill_req = 1'b1;
    tick(21);
    pulse_reset();
    check("midfill_state", 8'(wif.state), 8'(IDLE));
    check("midfill_level", 8'(wif.level), 8'd0);
    check("midfill_waterflow", 8'(wif.waterflow), 8'd1);
    check("midfill_fault_count", 8'(wif.fault_count), 8'd0);
    wif.fill_req = 1'b0;

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      tick(1);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) wif.raw_level = 3'($urandom_range(0, 7));
      wif.raw_flow = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 24) == 0) wif.fill_req = ~wif.fill_req;
      wif.retry = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) wif.target_level = 3'($urandom_range(0, 7));
    end
    reset = 1'b0;
    tick(2);

    check("fault_queue_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
